// File: rtl/ddr3_burst_sched.sv
// Burst scheduler that uses DDR3 as a ring FIFO: moves fixed-length bursts from an
// upstream FWFT FIFO into DDR3 and back out to a downstream FIFO, alternating fairly.
module ddr3_burst_sched #(
  parameter int          DATA_W      = 128,
  parameter int          BURST_LEN   = 64,
  parameter int          DEPTH_WORDS = 1048576,
  parameter logic [29:0] ADDR_BASE   = 30'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        src_level,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_rd_en,
  input  logic [9:0]        snk_space,
  output logic [DATA_W-1:0] snk_data,
  output logic              snk_wr_en,
  output logic [6:0]        u_wr_len,
  output logic [29:0]       u_wr_addr,
  output logic [DATA_W-1:0] u_wr_data,
  output logic              u_wr_en,
  output logic              u_wr_cmd_en,
  input  logic              u_wr_cmd_done,
  input  logic              u_wr_rdy,
  output logic [6:0]        u_rd_len,
  output logic [29:0]       u_rd_addr,
  input  logic [DATA_W-1:0] u_rd_data,
  output logic              u_rd_en,
  output logic              u_rd_cmd_en,
  input  logic              u_rd_cmd_done,
  input  logic              u_rd_rdy,
  output logic [20:0]       occupancy,
  output logic              busy
);

  localparam int PTR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BYTES = DATA_W / 8;

  localparam logic [6:0]  BL7     = 7'(BURST_LEN);
  localparam logic [20:0] BL21    = 21'(BURST_LEN);
  localparam logic [31:0] BL32    = 32'(BURST_LEN);
  localparam logic [31:0] OCC_MAX = 32'(DEPTH_WORDS - BURST_LEN);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_FILL = 3'd1;
  localparam logic [2:0] WR_CMD  = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] RD_CMD  = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;

  logic [2:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [20:0]      occ;
  logic [6:0]       beat;
  logic             last_grant;  // 0: write was granted last, 1: read
  logic             wr_ok;
  logic             rd_ok;

  // Read completion is counted from u_rd_rdy beats, so the command-done strobe is not needed.
  logic unused_inputs;
  assign unused_inputs = u_rd_cmd_done;

  function automatic logic [29:0] ptr_to_addr(input logic [PTR_W-1:0] p);
    return ADDR_BASE + 30'(32'(p) * BYTES);
  endfunction

  // Power-of-two depth that is a multiple of BURST_LEN: a burst never crosses the wrap.
  assign wr_ptr_next = PTR_W'((32'(wr_ptr) + BL32) % 32'(DEPTH_WORDS));
  assign rd_ptr_next = PTR_W'((32'(rd_ptr) + BL32) % 32'(DEPTH_WORDS));

  assign wr_ok = ({22'd0, src_level} >= BL32) && ({11'd0, occ} <= OCC_MAX);
  assign rd_ok = ({11'd0, occ} >= BL32) && ({22'd0, snk_space} >= BL32);

  assign u_wr_len    = BL7;
  assign u_rd_len    = BL7;
  assign u_wr_data   = src_data;
  assign src_rd_en   = u_wr_rdy;
  assign snk_data    = u_rd_data;
  assign snk_wr_en   = u_rd_rdy;
  assign u_wr_en     = (state == WR_FILL);
  assign u_wr_cmd_en = (state == WR_CMD);
  assign u_rd_cmd_en = (state == RD_CMD);
  assign u_rd_en     = (state == RD_DATA);
  assign busy        = (state != IDLE);
  assign occupancy   = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      beat       <= '0;
      last_grant <= 1'b0;
      u_wr_addr  <= ADDR_BASE;
      u_rd_addr  <= ADDR_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok && (!rd_ok || last_grant)) begin
            state      <= WR_FILL;
            beat       <= '0;
            last_grant <= 1'b0;
          end else if (rd_ok) begin
            state      <= RD_CMD;
            last_grant <= 1'b1;
          end
        end
        WR_FILL: begin
          if (u_wr_rdy) begin
            beat <= beat + 7'd1;
            if (beat == BL7 - 7'd1) state <= WR_CMD;
          end
        end
        WR_CMD: state <= WR_WAIT;
        WR_WAIT: begin
          if (u_wr_cmd_done) begin
            wr_ptr    <= wr_ptr_next;
            u_wr_addr <= ptr_to_addr(wr_ptr_next);
            occ       <= occ + BL21;
            state     <= IDLE;
          end
        end
        RD_CMD: begin
          beat  <= '0;
          state <= RD_DATA;
        end
        RD_DATA: begin
          if (u_rd_rdy) begin
            beat <= beat + 7'd1;
            if (beat == BL7 - 7'd1) begin
              rd_ptr    <= rd_ptr_next;
              u_rd_addr <= ptr_to_addr(rd_ptr_next);
              occ       <= occ - BL21;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_burst_sched.sv
// Testbench for ddr3_burst_sched: a behavioural MCB/FIFO model plus a scoreboard of
// written words that is checked in order as the scheduler reads bursts back out.
`timescale 1ns/1ps
module tb_ddr3_burst_sched;

  localparam int          DATA_W = 128;
  localparam int          BL     = 64;
  localparam int          DEPTH  = 256;
  localparam logic [29:0] BASE   = 30'h0001_0000;
  localparam logic [29:0] STEP   = 30'(BL * DATA_W / 8);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [9:0]        src_level = '0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_rd_en;
  logic [9:0]        snk_space = '0;
  logic [DATA_W-1:0] snk_data;
  logic              snk_wr_en;
  logic [6:0]        u_wr_len;
  logic [29:0]       u_wr_addr;
  logic [DATA_W-1:0] u_wr_data;
  logic              u_wr_en;
  logic              u_wr_cmd_en;
  logic              u_wr_cmd_done = 1'b0;
  logic              u_wr_rdy = 1'b0;
  logic [6:0]        u_rd_len;
  logic [29:0]       u_rd_addr;
  logic [DATA_W-1:0] u_rd_data = '0;
  logic              u_rd_en;
  logic              u_rd_cmd_en;
  logic              u_rd_cmd_done = 1'b0;
  logic              u_rd_rdy = 1'b0;
  logic [20:0]       occupancy;
  logic              busy;

  ddr3_burst_sched #(
    .DATA_W(DATA_W), .BURST_LEN(BL), .DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_level(src_level), .src_data(src_data), .src_rd_en(src_rd_en),
    .snk_space(snk_space), .snk_data(snk_data), .snk_wr_en(snk_wr_en),
    .u_wr_len(u_wr_len), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
    .u_wr_en(u_wr_en), .u_wr_cmd_en(u_wr_cmd_en), .u_wr_cmd_done(u_wr_cmd_done),
    .u_wr_rdy(u_wr_rdy),
    .u_rd_len(u_rd_len), .u_rd_addr(u_rd_addr), .u_rd_data(u_rd_data),
    .u_rd_en(u_rd_en), .u_rd_cmd_en(u_rd_cmd_en), .u_rd_cmd_done(u_rd_cmd_done),
    .u_rd_rdy(u_rd_rdy),
    .occupancy(occupancy), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem [bit [29:0]];
  logic [DATA_W-1:0] wbuf[$];
  logic [DATA_W-1:0] rbuf[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [29:0]       wcmd_addrs[$];
  logic [29:0]       rcmd_addrs[$];
  bit                grant_seq[$];   // 1 = read command, 0 = write command
  logic [DATA_W-1:0] src_word = 128'd1;
  int wcmd_count = 0;
  int rcmd_count = 0;
  int last_burst_beats = 0;
  int stall_at = -1;
  int stall_left = 0;
  int wdone_cnt = 0;
  int rd_tick = 0;
  bit prev_wcmd = 1'b0;
  bit prev_rcmd = 1'b0;

  // MCB and FIFO model: beats offered at one negedge are committed at the next.
  task automatic mcb_model();
    logic [DATA_W-1:0] exp_word;
    src_data = src_word;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_wr_rdy = 1'b0; u_rd_rdy = 1'b0; u_wr_cmd_done = 1'b0;
        wdone_cnt = 0; wbuf.delete(); rbuf.delete();
        prev_wcmd = 1'b0; prev_rcmd = 1'b0;
      end else begin
        if (u_wr_rdy || u_wr_en) begin
          tests_run++;
          if (src_rd_en !== u_wr_rdy) begin
            tests_failed++;
            $display("FAIL src_rd_en_track: src_rd_en=%b u_wr_rdy=%b", src_rd_en, u_wr_rdy);
          end
        end
        if (u_wr_rdy) begin
          wbuf.push_back(u_wr_data);
          src_word = src_word + 1'b1;
        end
        if (u_rd_rdy) begin
          exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          tests_run++;
          if (snk_wr_en !== 1'b1 || snk_data !== exp_word) begin
            tests_failed++;
            $display("FAIL readback: snk_wr_en=%b snk_data=%h expected %h", snk_wr_en, snk_data, exp_word);
          end
          void'(rbuf.pop_front());
        end
        u_wr_cmd_done = 1'b0;
        if (wdone_cnt > 0) begin
          wdone_cnt--;
          if (wdone_cnt == 0) u_wr_cmd_done = 1'b1;
        end
        if (u_wr_cmd_en || u_rd_cmd_en) begin
          tests_run++;
          if ((u_wr_cmd_en && u_rd_cmd_en) || (u_wr_cmd_en && prev_wcmd) || (u_rd_cmd_en && prev_rcmd)) begin
            tests_failed++;
            $display("FAIL cmd_pulse: wr=%b rd=%b prev_wr=%b prev_rd=%b", u_wr_cmd_en, u_rd_cmd_en, prev_wcmd, prev_rcmd);
          end
        end
        if (u_wr_cmd_en) begin
          wcmd_count++;
          wcmd_addrs.push_back(u_wr_addr);
          grant_seq.push_back(1'b0);
          last_burst_beats = wbuf.size();
          foreach (wbuf[i]) begin
            mem[u_wr_addr + 30'(i * 16)] = wbuf[i];
            exp_q.push_back(wbuf[i]);
          end
          $display("[TB] WR burst addr=%h beats=%0d", u_wr_addr, wbuf.size());
          wbuf.delete();
          wdone_cnt = 3;
        end
        if (u_rd_cmd_en) begin
          rcmd_count++;
          rcmd_addrs.push_back(u_rd_addr);
          grant_seq.push_back(1'b1);
          for (int i = 0; i < BL; i++)
            rbuf.push_back(mem.exists(u_rd_addr + 30'(i * 16)) ? mem[u_rd_addr + 30'(i * 16)] : '0);
          $display("[TB] RD burst addr=%h", u_rd_addr);
        end
        prev_wcmd = u_wr_cmd_en;
        prev_rcmd = u_rd_cmd_en;
        u_wr_rdy = 1'b0;
        if (u_wr_en) begin
          if (stall_at >= 0 && wbuf.size() == stall_at && stall_left > 0) stall_left--;
          else u_wr_rdy = 1'b1;
        end
        src_data = src_word;
        u_rd_rdy = 1'b0;
        if (u_rd_en && rbuf.size() > 0) begin
          rd_tick++;
          if (rd_tick % 7 != 3) begin
            u_rd_rdy  = 1'b1;
            u_rd_data = rbuf[0];
          end
        end
      end
    end
  endtask

  task automatic wait_occ(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (occupancy == 21'(target) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || u_wr_en !== 1'b0 || u_wr_cmd_en !== 1'b0 || u_rd_en !== 1'b0 ||
        u_rd_cmd_en !== 1'b0 || src_rd_en !== 1'b0 || snk_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b wr_en=%b wr_cmd=%b rd_en=%b rd_cmd=%b, all must be 0",
               busy, u_wr_en, u_wr_cmd_en, u_rd_en, u_rd_cmd_en);
    end
    tests_run++;
    if (u_wr_addr !== BASE || u_rd_addr !== BASE) begin
      tests_failed++;
      $display("FAIL reset_addr: wr=%h rd=%h expected %h", u_wr_addr, u_rd_addr, BASE);
    end
    tests_run++;
    if (occupancy !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_occ: got %0d expected 0", occupancy);
    end
    tests_run++;
    if (u_wr_len !== 7'(BL) || u_rd_len !== 7'(BL)) begin
      tests_failed++;
      $display("FAIL burst_len: wr=%0d rd=%0d expected %0d", u_wr_len, u_rd_len, BL);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    int w0;
    logic [29:0] a;
    w0 = wcmd_count;
    src_level = 10'd64;
    wait_occ(BL, 400, ok);
    src_level = 10'd0;
    a = (wcmd_addrs.size() > 0) ? wcmd_addrs[$] : 'x;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_write_done: occupancy=%0d expected %0d", occupancy, BL); end
    tests_run++;
    if (wcmd_count - w0 != 1) begin tests_failed++; $display("FAIL single_write_pulses: got %0d expected 1", wcmd_count - w0); end
    tests_run++;
    if (last_burst_beats != BL) begin tests_failed++; $display("FAIL single_write_beats: got %0d expected %0d", last_burst_beats, BL); end
    tests_run++;
    if (a !== BASE) begin tests_failed++; $display("FAIL single_write_addr: got %h expected %h", a, BASE); end
    tests_run++;
    if (u_wr_addr !== BASE + STEP) begin tests_failed++; $display("FAIL next_wr_addr: got %h expected %h", u_wr_addr, BASE + STEP); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [29:0] a;
    stall_at = 20;
    stall_left = 5;
    src_level = 10'd64;
    wait_occ(2 * BL, 400, ok);
    src_level = 10'd0;
    a = (wcmd_addrs.size() > 0) ? wcmd_addrs[$] : 'x;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_done: occupancy=%0d expected %0d", occupancy, 2 * BL); end
    tests_run++;
    if (stall_left != 0) begin tests_failed++; $display("FAIL bp_stall_used: %0d stall cycles left, expected 0", stall_left); end
    tests_run++;
    if (last_burst_beats != BL) begin tests_failed++; $display("FAIL bp_beats: got %0d expected %0d", last_burst_beats, BL); end
    tests_run++;
    if (a !== BASE + STEP) begin tests_failed++; $display("FAIL bp_addr: got %h expected %h", a, BASE + STEP); end
    stall_at = -1;
  endtask

  task automatic test_round_robin();
    int g0;
    logic [20:0] prev;
    logic [20:0] occ_seq[$];
    bit done;
    done = 1'b0;
    g0 = grant_seq.size();
    prev = occupancy;
    src_level = 10'd64;
    snk_space = 10'd512;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (occupancy !== prev) begin occ_seq.push_back(occupancy); prev = occupancy; end
      if (grant_seq.size() - g0 >= 3) begin
        src_level = 10'd0;
        snk_space = 10'd0;
        if (!busy) begin done = 1'b1; break; end
      end
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL rr_timeout: %0d grants seen, expected 3", grant_seq.size() - g0); end
    tests_run++;
    if (grant_seq.size() - g0 != 3 || grant_seq[g0] !== 1'b1 || grant_seq[g0+1] !== 1'b0 || grant_seq[g0+2] !== 1'b1)
      begin tests_failed++; $display("FAIL rr_order: got %p expected read,write,read", grant_seq[g0:$]); end
    tests_run++;
    if (occ_seq.size() != 3 || occ_seq[0] !== 21'd64 || occ_seq[1] !== 21'd128 || occ_seq[2] !== 21'd64)
      begin tests_failed++; $display("FAIL rr_occ_seq: got %p expected 64,128,64", occ_seq); end
    tests_run++;
    if (exp_q.size() != 64) begin tests_failed++; $display("FAIL rr_scoreboard: %0d words pending, expected 64", exp_q.size()); end
  endtask

  task automatic test_wrap_full();
    bit ok;
    int w0;
    int r0;
    w0 = wcmd_addrs.size();
    src_level = 10'd100;
    wait_occ(DEPTH, 1200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL fill_done: occupancy=%0d expected %0d", occupancy, DEPTH); end
    tests_run++;
    if (wcmd_addrs.size() - w0 != 3 || wcmd_addrs[w0] !== BASE + 3 * STEP || wcmd_addrs[w0+1] !== BASE ||
        wcmd_addrs[w0+2] !== BASE + STEP)
      begin tests_failed++; $display("FAIL wr_wrap_addrs: got %p expected base+c00,base,base+400", wcmd_addrs[w0:$]); end
    w0 = wcmd_count;
    repeat (50) @(negedge clk);
    tests_run++;
    if (wcmd_count != w0 || busy !== 1'b0 || occupancy !== 21'(DEPTH))
      begin tests_failed++; $display("FAIL full_blocks_write: new_writes=%0d busy=%b occupancy=%0d expected 0,0,%0d", wcmd_count - w0, busy, occupancy, DEPTH); end
    src_level = 10'd0;
    snk_space = 10'd512;
    wait_occ(DEPTH - BL, 400, ok);
    snk_space = 10'd0;
    tests_run++;
    if (!ok || rcmd_addrs[$] !== BASE + 2 * STEP)
      begin tests_failed++; $display("FAIL read_after_full: occupancy=%0d addr=%h expected %0d,%h", occupancy, rcmd_addrs[$], DEPTH - BL, BASE + 2 * STEP); end
    src_level = 10'd64;
    wait_occ(DEPTH, 400, ok);
    src_level = 10'd0;
    tests_run++;
    if (!ok || wcmd_addrs[$] !== BASE + 2 * STEP || u_wr_addr !== BASE + 3 * STEP)
      begin tests_failed++; $display("FAIL refill_write: occupancy=%0d addr=%h next=%h expected %0d,%h,%h", occupancy, wcmd_addrs[$], u_wr_addr, DEPTH, BASE + 2 * STEP, BASE + 3 * STEP); end
    r0 = rcmd_addrs.size();
    snk_space = 10'd512;
    wait_occ(0, 1500, ok);
    tests_run++;
    if (!ok || rcmd_addrs.size() - r0 != 4 || rcmd_addrs[r0] !== BASE + 3 * STEP || rcmd_addrs[r0+1] !== BASE)
      begin tests_failed++; $display("FAIL drain_wrap: occupancy=%0d reads=%p expected 0 with base+c00,base,...", occupancy, rcmd_addrs[r0:$]); end
    r0 = rcmd_count;
    repeat (30) @(negedge clk);
    snk_space = 10'd0;
    tests_run++;
    if (rcmd_count != r0 || busy !== 1'b0 || exp_q.size() != 0 || u_rd_addr !== BASE + 3 * STEP)
      begin tests_failed++; $display("FAIL empty_blocks_read: new_reads=%0d busy=%b pending=%0d rd_addr=%h expected 0,0,0,%h", rcmd_count - r0, busy, exp_q.size(), u_rd_addr, BASE + 3 * STEP); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int wc;
    wc = wcmd_count;
    ok = 1'b0;
    src_level = 10'd64;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wbuf.size() >= 30) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL mid_burst_reach: beats=%0d expected 30", wbuf.size()); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || u_wr_en !== 1'b0 || occupancy !== 21'd0 || u_wr_addr !== BASE || u_rd_addr !== BASE)
      begin tests_failed++; $display("FAIL mid_burst_reset: busy=%b wr_en=%b occupancy=%0d wr_addr=%h rd_addr=%h expected 0,0,0,%h,%h", busy, u_wr_en, occupancy, u_wr_addr, u_rd_addr, BASE, BASE); end
    src_level = 10'd0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (wcmd_count != wc || busy !== 1'b0)
      begin tests_failed++; $display("FAIL no_cmd_after_reset: pulses=%0d busy=%b expected 0,0", wcmd_count - wc, busy); end
    src_level = 10'd64;
    wait_occ(BL, 400, ok);
    src_level = 10'd0;
    tests_run++;
    if (!ok || wcmd_addrs[$] !== BASE || u_wr_addr !== BASE + STEP)
      begin tests_failed++; $display("FAIL write_after_reset: occupancy=%0d addr=%h next=%h expected %0d,%h,%h", occupancy, wcmd_addrs[$], u_wr_addr, BL, BASE, BASE + STEP); end
  endtask

  initial begin
    fork
      mcb_model();
    join_none
    test_reset();
    test_single_write();
    test_backpressure();
    test_round_robin();
    test_wrap_full();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
